alu_issue_seq: RTL
==================

Name: alu_issue_seq

Overview:
- Multi-cycle issue sequencer that sits in front of the registered MIPS ALU and drives its operand and opcode inputs.
- Accepts one decoded-source instruction at a time: raw 32-bit word plus rs/rt register values.
- Issues X, Y and ALU_OP, waits out the ALU's one-clock registered latency, then captures Result, Result2, OF and Equal.
- Produces register writeback, HI/LO updates, branch decisions and overflow/illegal traps for the pipeline.

Parameters:
- RESET_HILO, 64'h0, reset value of {hi, lo}.

Ports:
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer idle; transfer occurs when in_valid & in_ready at a rising edge.
- instr  in  32  MIPS instruction word.
- rs_val  in  32  value of register rs.
- rt_val  in  32  value of register rt.
- alu_x  out  32  ALU X operand (registered).
- alu_y  out  32  ALU Y operand (registered).
- alu_op  out  4  ALU opcode (registered).
- alu_result  in  32  ALU Result.
- alu_result2  in  32  ALU Result2.
- alu_of  in  1  ALU signed overflow.
- alu_equal  in  1  ALU X==Y.
- wb_valid  out  1  one-cycle pulse: write wb_data to wb_reg.
- wb_reg  out  5  destination register.
- wb_data  out  32  writeback value.
- hi  out  32  HI register.
- lo  out  32  LO register.
- br_valid  out  1  one-cycle pulse: branch resolved.
- br_taken  out  1  branch outcome; valid with br_valid.
- ov_trap  out  1  one-cycle pulse: signed overflow trap.
- ill_trap  out  1  one-cycle pulse: unsupported instruction.
- done  out  1  one-cycle pulse for every accepted instruction, including trapped ones.

Behaviour:
- ALU opcode map:
  - 0 sll, 1 sra, 2 srl, 3 unsigned mul (Result2:Result), 4 divu (Result=quotient, Result2=remainder).
  - 5 add, 6 sub, 7 and, 8 or, 9 xor, A nor, B slt, C sltu.
- States and transitions:
  - IDLE -> ISSUE -> WAIT -> IDLE.
  - in_ready = (state==IDLE).
  - Accept edge T0: decode, register alu_x/alu_y/alu_op and latched control (dest, class), go to ISSUE.
  - T1: ALU samples operands; go to WAIT.
  - T2: capture ALU outputs and drive all result pulses for the cycle after T2; return to IDLE.
  - Throughput: one instruction per 3 clocks. Next accept possible at T3.
- Decode, R-type (opcode 0), dest = rd:
  - sll/srl/sra (funct 00/02/03): X=rt, Y={27'b0,shamt}.
  - sllv/srlv/srav (04/06/07): X=rt, Y=rs.
  - add/addu/sub/subu (20/21/22/23): X=rs, Y=rt.
  - and/or/xor/nor (24..27), slt/sltu (2A/2B): X=rs, Y=rt.
  - multu (19) and divu (1B): X=rs, Y=rt, no writeback.
  - mfhi (10) / mflo (12): issue op 7 with X=Y=0; wb_data = hi / lo at capture.
- Decode, I-type, dest = rt:
  - addi 08 / addiu 09 / slti 0A / sltiu 0B: Y = sign-extended imm.
  - andi 0C / ori 0D / xori 0E: Y = zero-extended imm.
  - lui 0F: X = zero-extended imm, Y=16, op 0.
  - beq 04 / bne 05: op 6, X=rs, Y=rt; br_valid=1, br_taken = alu_equal (beq) or ~alu_equal (bne); no writeback.
- Writeback and HI/LO:
  - wb_valid=1 only for writeback-class ops with dest != 0 and no trap.
  - multu: hi<=alu_result2, lo<=alu_result.
  - divu with rt_val!=0: hi<=alu_result2, lo<=alu_result. divu with rt_val==0 leaves hi/lo unchanged, no trap.
- Traps:
  - add, sub, addi: alu_of=1 -> ov_trap=1, wb suppressed. addu/subu/addiu never trap.
  - Any other opcode/funct -> ill_trap=1 after the same 3-state latency; ALU issued op 7 with X=Y=0.
- Pulse width: all pulses are exactly 1 cycle. wb_reg/wb_data/br_taken hold their last value otherwise.
- Reset (any time, including mid-operation): state=IDLE, in_ready=1, alu_x/alu_y/alu_op=0, all pulses 0, wb_reg/wb_data/br_taken=0, {hi,lo}=RESET_HILO. An in-flight instruction is discarded with no done.
- in_valid while busy: ignored; the source must hold it.

Test Plan:
- add r3,r1,r2 with rs=5, rt=7 -> 3 clocks after accept: wb_valid, wb_reg=3, wb_data=12, done.
- add with rs=32'h7FFFFFFF, rt=1 -> ov_trap=1, wb_valid=0. Same operands as addu -> wb_data=32'h80000000.
- multu rs=32'hFFFFFFFF, rt=2 -> hi=1, lo=32'hFFFFFFFE. Then mflo r4 -> wb_data=32'hFFFFFFFE. Then divu 100/7 -> lo=14, hi=2.
- beq with rs=rt=9 -> br_valid, br_taken=1. bne with same values -> br_taken=0. Neither asserts wb_valid.
- Back-to-back in_valid held high: in_ready low for 2 cycles after each accept. lui r5,0x1234 -> wb_data=32'h12340000. Dest r0 -> no wb_valid.
- Deassert reset_n during WAIT of a multu -> hi/lo=RESET_HILO, no done, in_ready=1 immediately. Unknown funct 3F -> ill_trap pulse.

Source files
------------

// File: rtl/alu_issue_seq.sv
// Three-state issue sequencer for the registered MIPS ALU. It decodes one instruction,
// drives the ALU operands, and turns the ALU results into writeback, HI/LO, branch and trap pulses.
module alu_issue_seq #(
   parameter logic [63:0] RESET_HILO = 64'h0
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   output logic [3:0]  alu_op,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_result2,
   input  logic        alu_of,
   input  logic        alu_equal,
   output logic        wb_valid,
   output logic [4:0]  wb_reg,
   output logic [31:0] wb_data,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        br_valid,
   output logic        br_taken,
   output logic        ov_trap,
   output logic        ill_trap,
   output logic        done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_WAIT  = 2'd2;

   localparam logic [3:0] OP_SLL  = 4'h0;
   localparam logic [3:0] OP_SRA  = 4'h1;
   localparam logic [3:0] OP_SRL  = 4'h2;
   localparam logic [3:0] OP_MULU = 4'h3;
   localparam logic [3:0] OP_DIVU = 4'h4;
   localparam logic [3:0] OP_ADD  = 4'h5;
   localparam logic [3:0] OP_SUB  = 4'h6;
   localparam logic [3:0] OP_AND  = 4'h7;
   localparam logic [3:0] OP_OR   = 4'h8;
   localparam logic [3:0] OP_XOR  = 4'h9;
   localparam logic [3:0] OP_NOR  = 4'hA;
   localparam logic [3:0] OP_SLT  = 4'hB;
   localparam logic [3:0] OP_SLTU = 4'hC;

   logic [1:0]  r_state;
   logic [31:0] r_alu_x;
   logic [31:0] r_alu_y;
   logic [3:0]  r_alu_op;
   logic [4:0]  r_dest;
   logic        r_cls_wb;
   logic        r_cls_mul;
   logic        r_cls_div;
   logic        r_div_zero;
   logic        r_cls_br;
   logic        r_br_ne;
   logic        r_cls_ovchk;
   logic        r_cls_ill;
   logic        r_sel_hi;
   logic        r_sel_lo;

   logic        r_wb_valid;
   logic [4:0]  r_wb_reg;
   logic [31:0] r_wb_data;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic        r_br_valid;
   logic        r_br_taken;
   logic        r_ov_trap;
   logic        r_ill_trap;
   logic        r_done;

   logic [5:0]  w_opc;
   logic [5:0]  w_fn;
   logic [4:0]  w_shamt;
   logic [31:0] w_simm;
   logic [31:0] w_zimm;
   logic        w_accept;
   logic        w_ov_hit;
   logic        w_unused;

   logic [31:0] w_x;
   logic [31:0] w_y;
   logic [3:0]  w_aop;
   logic [4:0]  w_dest;
   logic        w_wb;
   logic        w_mul;
   logic        w_div;
   logic        w_br;
   logic        w_bne;
   logic        w_ovchk;
   logic        w_ill;
   logic        w_mfhi;
   logic        w_mflo;

   assign w_opc    = instr[31:26];
   assign w_fn     = instr[5:0];
   assign w_shamt  = instr[10:6];
   assign w_simm   = {{16{instr[15]}}, instr[15:0]};
   assign w_zimm   = {16'h0000, instr[15:0]};
   assign w_unused = ^instr[25:21];

   assign in_ready = (r_state == S_IDLE);
   assign w_accept = in_valid & in_ready;
   assign w_ov_hit = r_cls_ovchk & alu_of;

   always_comb begin
      w_x     = rs_val;
      w_y     = rt_val;
      w_aop   = OP_AND;
      w_dest  = instr[15:11];
      w_wb    = 1'b0;
      w_mul   = 1'b0;
      w_div   = 1'b0;
      w_br    = 1'b0;
      w_bne   = 1'b0;
      w_ovchk = 1'b0;
      w_ill   = 1'b0;
      w_mfhi  = 1'b0;
      w_mflo  = 1'b0;
      if (w_opc == 6'h00) begin
         case (w_fn)
            6'h00: begin w_x = rt_val; w_y = {27'b0, w_shamt}; w_aop = OP_SLL; w_wb = 1'b1; end
            6'h02: begin w_x = rt_val; w_y = {27'b0, w_shamt}; w_aop = OP_SRL; w_wb = 1'b1; end
            6'h03: begin w_x = rt_val; w_y = {27'b0, w_shamt}; w_aop = OP_SRA; w_wb = 1'b1; end
            6'h04: begin w_x = rt_val; w_y = rs_val; w_aop = OP_SLL; w_wb = 1'b1; end
            6'h06: begin w_x = rt_val; w_y = rs_val; w_aop = OP_SRL; w_wb = 1'b1; end
            6'h07: begin w_x = rt_val; w_y = rs_val; w_aop = OP_SRA; w_wb = 1'b1; end
            6'h20: begin w_aop = OP_ADD;  w_wb = 1'b1; w_ovchk = 1'b1; end
            6'h21: begin w_aop = OP_ADD;  w_wb = 1'b1; end
            6'h22: begin w_aop = OP_SUB;  w_wb = 1'b1; w_ovchk = 1'b1; end
            6'h23: begin w_aop = OP_SUB;  w_wb = 1'b1; end
            6'h24: begin w_aop = OP_AND;  w_wb = 1'b1; end
            6'h25: begin w_aop = OP_OR;   w_wb = 1'b1; end
            6'h26: begin w_aop = OP_XOR;  w_wb = 1'b1; end
            6'h27: begin w_aop = OP_NOR;  w_wb = 1'b1; end
            6'h2A: begin w_aop = OP_SLT;  w_wb = 1'b1; end
            6'h2B: begin w_aop = OP_SLTU; w_wb = 1'b1; end
            6'h19: begin w_aop = OP_MULU; w_mul = 1'b1; end
            6'h1B: begin w_aop = OP_DIVU; w_div = 1'b1; end
            6'h10: begin w_x = '0; w_y = '0; w_wb = 1'b1; w_mfhi = 1'b1; end
            6'h12: begin w_x = '0; w_y = '0; w_wb = 1'b1; w_mflo = 1'b1; end
            default: begin w_x = '0; w_y = '0; w_ill = 1'b1; end
         endcase
      end else begin
         w_dest = instr[20:16];
         case (w_opc)
            6'h08: begin w_y = w_simm; w_aop = OP_ADD;  w_wb = 1'b1; w_ovchk = 1'b1; end
            6'h09: begin w_y = w_simm; w_aop = OP_ADD;  w_wb = 1'b1; end
            6'h0A: begin w_y = w_simm; w_aop = OP_SLT;  w_wb = 1'b1; end
            6'h0B: begin w_y = w_simm; w_aop = OP_SLTU; w_wb = 1'b1; end
            6'h0C: begin w_y = w_zimm; w_aop = OP_AND;  w_wb = 1'b1; end
            6'h0D: begin w_y = w_zimm; w_aop = OP_OR;   w_wb = 1'b1; end
            6'h0E: begin w_y = w_zimm; w_aop = OP_XOR;  w_wb = 1'b1; end
            6'h0F: begin w_x = w_zimm; w_y = 32'd16; w_aop = OP_SLL; w_wb = 1'b1; end
            6'h04: begin w_aop = OP_SUB; w_br = 1'b1; end
            6'h05: begin w_aop = OP_SUB; w_br = 1'b1; w_bne = 1'b1; end
            default: begin w_x = '0; w_y = '0; w_ill = 1'b1; end
         endcase
      end
   end

   // T0: accept and issue; T1: ALU samples operands; T2: capture
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= S_IDLE;
         r_alu_x     <= '0;
         r_alu_y     <= '0;
         r_alu_op    <= '0;
         r_dest      <= '0;
         r_cls_wb    <= 1'b0;
         r_cls_mul   <= 1'b0;
         r_cls_div   <= 1'b0;
         r_div_zero  <= 1'b0;
         r_cls_br    <= 1'b0;
         r_br_ne     <= 1'b0;
         r_cls_ovchk <= 1'b0;
         r_cls_ill   <= 1'b0;
         r_sel_hi    <= 1'b0;
         r_sel_lo    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_state     <= S_ISSUE;
                  r_alu_x     <= w_x;
                  r_alu_y     <= w_y;
                  r_alu_op    <= w_aop;
                  r_dest      <= w_dest;
                  r_cls_wb    <= w_wb;
                  r_cls_mul   <= w_mul;
                  r_cls_div   <= w_div;
                  r_div_zero  <= (rt_val == 32'h0);
                  r_cls_br    <= w_br;
                  r_br_ne     <= w_bne;
                  r_cls_ovchk <= w_ovchk;
                  r_cls_ill   <= w_ill;
                  r_sel_hi    <= w_mfhi;
                  r_sel_lo    <= w_mflo;
               end
            end
            S_ISSUE: r_state <= S_WAIT;
            S_WAIT:  r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // T2: results registered, visible as one-cycle pulses in the following cycle
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_wb_valid <= 1'b0;
         r_wb_reg   <= '0;
         r_wb_data  <= '0;
         r_hi       <= RESET_HILO[63:32];
         r_lo       <= RESET_HILO[31:0];
         r_br_valid <= 1'b0;
         r_br_taken <= 1'b0;
         r_ov_trap  <= 1'b0;
         r_ill_trap <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_wb_valid <= 1'b0;
         r_br_valid <= 1'b0;
         r_ov_trap  <= 1'b0;
         r_ill_trap <= 1'b0;
         r_done     <= 1'b0;
         if (r_state == S_WAIT) begin
            r_done     <= 1'b1;
            r_ill_trap <= r_cls_ill;
            r_ov_trap  <= w_ov_hit;
            if (r_cls_wb && !w_ov_hit && (r_dest != 5'd0)) begin
               r_wb_valid <= 1'b1;
               r_wb_reg   <= r_dest;
               r_wb_data  <= r_sel_hi ? r_hi : (r_sel_lo ? r_lo : alu_result);
            end
            if (r_cls_br) begin
               r_br_valid <= 1'b1;
               r_br_taken <= alu_equal ^ r_br_ne;
            end
            // divide by zero silently keeps the previous HI/LO
            if (r_cls_mul || (r_cls_div && !r_div_zero)) begin
               r_hi <= alu_result2;
               r_lo <= alu_result;
            end
         end
      end
   end

   assign alu_x    = r_alu_x;
   assign alu_y    = r_alu_y;
   assign alu_op   = r_alu_op;
   assign wb_valid = r_wb_valid;
   assign wb_reg   = r_wb_reg;
   assign wb_data  = r_wb_data;
   assign hi       = r_hi;
   assign lo       = r_lo;
   assign br_valid = r_br_valid;
   assign br_taken = r_br_taken;
   assign ov_trap  = r_ov_trap;
   assign ill_trap = r_ill_trap;
   assign done     = r_done;

endmodule
